mmio_initiator: RTL and testbench

MMIO_INITIATOR -- requirements
Module: mmio_initiator

---
 rtl/mmio_initiator.sv | 213 +++++++++++++++++++++
 tb/tb_mmio_initiator.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_initiator.sv
// MMIO bus initiator: a request FIFO feeds a single-outstanding bus sequencer.
// Reads hold the strobe for RD_LAT+1 cycles and return data on a valid/ready response port.
module mmio_initiator #(
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [20:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        mmio_cs,
  output logic        mmio_wr,
  output logic        mmio_rd,
  output logic [20:0] mmio_addr,
  output logic [31:0] mmio_wr_data,
  input  logic [31:0] mmio_rd_data,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 54;
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [1:0]  HOLD_INIT = 2'(RD_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic logic ptr_full(input logic [AW:0] wp, input logic [AW:0] rp);
    return (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  endfunction

  logic [EW-1:0] mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [AW:0]   wr_ptr_nxt_s;
  logic [AW:0]   rd_ptr_nxt_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic [EW-1:0] head_s;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [1:0]    hold_r;
  logic [1:0]    hold_nxt_s;

  logic          req_ready_r;
  logic          req_ready_nxt_s;
  logic          busy_r;
  logic          busy_nxt_s;
  logic          rsp_valid_r;
  logic          rsp_valid_nxt_s;
  logic [31:0]   rsp_rdata_r;
  logic [31:0]   rsp_rdata_nxt_s;
  logic          cs_r;
  logic          cs_nxt_s;
  logic          wr_r;
  logic          wr_nxt_s;
  logic          rd_r;
  logic          rd_nxt_s;
  logic [20:0]   addr_r;
  logic [20:0]   addr_nxt_s;
  logic [31:0]   wdata_r;
  logic [31:0]   wdata_nxt_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign push_s  = req_valid && req_ready_r;
  assign head_s  = mem_r[rd_ptr_r[AW-1:0]];

  // FIFO storage; entries are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {req_wr, req_addr, req_wdata};
    end
  end

  // Next pointer values and the flags that are registered from them.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    req_ready_nxt_s = !ptr_full(wr_ptr_nxt_s, rd_ptr_nxt_s);
    busy_nxt_s      = (wr_ptr_nxt_s != rd_ptr_nxt_s) || (state_nxt_s != IDLE);
  end

  // Sequencer next state and next values of every registered bus/response output.
  always_comb begin
    state_nxt_s     = state_r;
    hold_nxt_s      = hold_r;
    pop_s           = 1'b0;
    cs_nxt_s        = 1'b0;
    wr_nxt_s        = 1'b0;
    rd_nxt_s        = 1'b0;
    addr_nxt_s      = 21'h0;
    wdata_nxt_s     = 32'h0;
    rsp_valid_nxt_s = rsp_valid_r;
    rsp_rdata_nxt_s = rsp_rdata_r;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          cs_nxt_s    = 1'b1;
          addr_nxt_s  = head_s[52:32];
          wdata_nxt_s = head_s[31:0];
          if (head_s[53]) begin
            state_nxt_s = WRITE;
            wr_nxt_s    = 1'b1;
          end else begin
            state_nxt_s = READ;
            rd_nxt_s    = 1'b1;
            hold_nxt_s  = HOLD_INIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        state_nxt_s = IDLE;
      end
      READ: begin
        // The edge ending the last strobe cycle captures the slot data.
        if (hold_r == 2'd0) begin
          state_nxt_s     = RESP;
          rsp_valid_nxt_s = 1'b1;
          rsp_rdata_nxt_s = mmio_rd_data;
        end else begin
          hold_nxt_s  = hold_r - 2'd1;
          cs_nxt_s    = 1'b1;
          rd_nxt_s    = 1'b1;
          addr_nxt_s  = addr_r;
          wdata_nxt_s = wdata_r;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s     = IDLE;
          rsp_valid_nxt_s = 1'b0;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        hold_nxt_s      = 2'd0;
        rsp_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State, pointers and all outputs are registered with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      state_r     <= IDLE;
      hold_r      <= 2'd0;
      req_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0;
      cs_r        <= 1'b0;
      wr_r        <= 1'b0;
      rd_r        <= 1'b0;
      addr_r      <= 21'h0;
      wdata_r     <= 32'h0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      state_r     <= state_nxt_s;
      hold_r      <= hold_nxt_s;
      req_ready_r <= req_ready_nxt_s;
      busy_r      <= busy_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_rdata_r <= rsp_rdata_nxt_s;
      cs_r        <= cs_nxt_s;
      wr_r        <= wr_nxt_s;
      rd_r        <= rd_nxt_s;
      addr_r      <= addr_nxt_s;
      wdata_r     <= wdata_nxt_s;
    end
  end

  assign req_ready    = req_ready_r;
  assign busy         = busy_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_rdata    = rsp_rdata_r;
  assign mmio_cs      = cs_r;
  assign mmio_wr      = wr_r;
  assign mmio_rd      = rd_r;
  assign mmio_addr    = addr_r;
  assign mmio_wr_data = wdata_r;

endmodule

// File: tb/tb_mmio_initiator.sv
// Directed and randomized bench for mmio_initiator: one instance with RD_LAT=2
// for most scenarios, a second with RD_LAT=3 for the reset-during-read case.
`timescale 1ns/1ps
module tb_mmio_initiator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_wr, rsp_valid, rsp_ready;
  logic [20:0] req_addr, mmio_addr;
  logic [31:0] req_wdata, rsp_rdata, mmio_wr_data, mmio_rd_data;
  logic        mmio_cs, mmio_wr, mmio_rd, busy;

  logic        req_valid3, req_ready3, req_wr3, rsp_valid3, rsp_ready3;
  logic [20:0] req_addr3, mmio_addr3;
  logic [31:0] req_wdata3, rsp_rdata3, mmio_wr_data3;
  logic        mmio_cs3, mmio_wr3, mmio_rd3, busy3;

  int          tests = 0;
  int          fails = 0;

  logic [31:0] slot_mem [16];
  logic        use_fixed;
  logic [31:0] fixed_rd;

  mmio_initiator #(.DEPTH(4), .RD_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_data(mmio_rd_data), .busy(busy)
  );

  mmio_initiator #(.DEPTH(4), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_wr(req_wr3),
    .req_addr(req_addr3), .req_wdata(req_wdata3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3),
    .mmio_cs(mmio_cs3), .mmio_wr(mmio_wr3), .mmio_rd(mmio_rd3),
    .mmio_addr(mmio_addr3), .mmio_wr_data(mmio_wr_data3),
    .mmio_rd_data(32'hCAFEF00D), .busy(busy3)
  );

  // Slot model: 16-word register file decoded on the low address bits.
  assign mmio_rd_data = !mmio_rd ? 32'h0 : (use_fixed ? fixed_rd : slot_mem[mmio_addr[3:0]]);

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) slot_mem[i] <= 32'h0;
    end else if (mmio_cs && mmio_wr) begin
      slot_mem[mmio_addr[3:0]] <= mmio_wr_data;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({req_ready, rsp_valid, mmio_cs, mmio_wr, mmio_rd, busy} !== 6'b0)
      $display("FAIL reset_ctrl: got rdy/rv/cs/wr/rd/busy=%b expected 000000",
               {req_ready, rsp_valid, mmio_cs, mmio_wr, mmio_rd, busy});
    if ({req_ready, rsp_valid, mmio_cs, mmio_wr, mmio_rd, busy} !== 6'b0) fails++;
    tests++;
    if (rsp_rdata !== 32'h0 || mmio_addr !== 21'h0 || mmio_wr_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h expected all 0",
               rsp_rdata, mmio_addr, mmio_wr_data);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got req_ready=%b expected 1", req_ready);
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 21'h000080; req_wdata = 32'hDEADBEEF;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL write_ready: got %b expected 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (mmio_cs !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL write_t1: got cs=%b busy=%b expected cs=0 busy=1", mmio_cs, busy);
    end
    @(negedge clk);
    tests++;
    if ({mmio_cs, mmio_wr, mmio_rd} !== 3'b110 || mmio_addr !== 21'h000080 ||
        mmio_wr_data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL write_strobe: got cs/wr/rd=%b addr=%h data=%h expected 110 000080 deadbeef",
               {mmio_cs, mmio_wr, mmio_rd}, mmio_addr, mmio_wr_data);
    end
    @(negedge clk);
    tests++;
    if ({mmio_cs, mmio_wr, mmio_rd} !== 3'b000 || mmio_addr !== 21'h0 ||
        mmio_wr_data !== 32'h0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL write_after: got cs/wr/rd=%b addr=%h data=%h rv=%b busy=%b expected all 0",
               {mmio_cs, mmio_wr, mmio_rd}, mmio_addr, mmio_wr_data, rsp_valid, busy);
    end
  endtask

  task automatic test_read();
    use_fixed = 1'b1; fixed_rd = 32'h12345678; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 21'h1FFFFF; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (mmio_cs !== 1'b0) begin
      fails++;
      $display("FAIL read_t1: got cs=%b expected 0", mmio_cs);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if ({mmio_cs, mmio_wr, mmio_rd} !== 3'b101 || mmio_addr !== 21'h1FFFFF || rsp_valid !== 1'b0) begin
        fails++;
        $display("FAIL read_strobe%0d: got cs/wr/rd=%b addr=%h rv=%b expected 101 1fffff 0",
                 k, {mmio_cs, mmio_wr, mmio_rd}, mmio_addr, rsp_valid);
      end
    end
    @(negedge clk);
    tests++;
    if ({mmio_cs, mmio_wr, mmio_rd} !== 3'b000 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678) begin
      fails++;
      $display("FAIL read_resp: got cs/wr/rd=%b rv=%b rdata=%h expected 000 1 12345678",
               {mmio_cs, mmio_wr, mmio_rd}, rsp_valid, rsp_rdata);
    end
    fixed_rd = 32'hFFFF0000;
    repeat (3) @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || mmio_cs !== 1'b0) begin
      fails++;
      $display("FAIL read_hold: got rv=%b rdata=%h cs=%b expected 1 12345678 0",
               rsp_valid, rsp_rdata, mmio_cs);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL read_done: got rv=%b busy=%b expected 0 0", rsp_valid, busy);
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 21'h000200; req_wdata = 32'h11110000;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      if (j < 2) begin
        req_addr  = 21'h000200 + 21'(4 * (j + 1));
        req_wdata = 32'h11110000 + 32'(j + 1);
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      if (mmio_wr) begin
        tests++;
        if (j !== 2 * n + 1 || mmio_addr !== 21'h000200 + 21'(4 * n) ||
            mmio_wr_data !== 32'h11110000 + 32'(n)) begin
          fails++;
          $display("FAIL b2b_write%0d: got cycle=%0d addr=%h data=%h expected cycle=%0d addr=%h data=%h",
                   n, j, mmio_addr, mmio_wr_data, 2 * n + 1, 21'h000200 + 21'(4 * n),
                   32'h11110000 + 32'(n));
        end
        n++;
      end
    end
    tests++;
    if (n !== 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d writes expected 3", n);
    end
  endtask

  // Stall the sequencer on an unconsumed read while n writes stream in behind it.
  task automatic test_stall(input int n);
    int  i = 0;
    int  k = 0;
    bit  released = 1'b0;
    bit  full_checked = 1'b0;
    bit  accept;
    use_fixed = 1'b1; fixed_rd = 32'hA5A55A5A; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 21'h000040; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_wr = 1'b1; req_addr = 21'h000300; req_wdata = 32'hC0DE0000 + 32'(n << 8);
    for (int cyc = 0; cyc < 300 && (k < n || !released); cyc++) begin
      @(negedge clk);
      if (mmio_wr) begin
        tests++;
        if (!released || k >= n || mmio_addr !== 21'h000300 + 21'(4 * k) ||
            mmio_wr_data !== 32'hC0DE0000 + 32'(n << 8) + 32'(k)) begin
          fails++;
          $display("FAIL stall%0d_write%0d: got addr=%h data=%h released=%b expected addr=%h data=%h released=1",
                   n, k, mmio_addr, mmio_wr_data, released, 21'h000300 + 21'(4 * k),
                   32'hC0DE0000 + 32'(n << 8) + 32'(k));
        end
        k++;
      end
      if (!released && i == 4 && !full_checked) begin
        full_checked = 1'b1;
        tests++;
        if (req_ready !== 1'b0) begin
          fails++;
          $display("FAIL stall%0d_full: got req_ready=%b expected 0", n, req_ready);
        end
      end
      if (!released && rsp_valid && cyc >= 12) begin
        tests++;
        if (rsp_rdata !== 32'hA5A55A5A) begin
          fails++;
          $display("FAIL stall%0d_rdata: got %h expected a5a55a5a", n, rsp_rdata);
        end
        rsp_ready = 1'b1;
        released  = 1'b1;
      end
      accept = req_valid && req_ready;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      if (accept) begin
        i++;
        if (i < n) begin
          req_addr  = 21'h000300 + 21'(4 * i);
          req_wdata = 32'hC0DE0000 + 32'(n << 8) + 32'(i);
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    tests++;
    if (k !== n || !released) begin
      fails++;
      $display("FAIL stall%0d_count: got %0d writes released=%b expected %0d released=1", n, k, released, n);
    end
    for (int w = 0; w < 50 && busy; w++) @(negedge clk);
    use_fixed = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    bit bad = 1'b0;
    rsp_ready3 = 1'b0;
    @(negedge clk);
    req_valid3 = 1'b1; req_wr3 = 1'b0; req_addr3 = 21'h000123; req_wdata3 = 32'h0;
    @(posedge clk); #1;
    req_wr3 = 1'b1; req_addr3 = 21'h000200; req_wdata3 = 32'h00000055;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    @(negedge clk);
    tests++;
    if ({mmio_cs3, mmio_rd3} !== 2'b11 || mmio_addr3 !== 21'h000123) begin
      fails++;
      $display("FAIL rmr_strobe1: got cs/rd=%b addr=%h expected 11 000123", {mmio_cs3, mmio_rd3}, mmio_addr3);
    end
    @(posedge clk); #2;
    tests++;
    if ({mmio_cs3, mmio_rd3} !== 2'b11) begin
      fails++;
      $display("FAIL rmr_strobe2: got cs/rd=%b expected 11", {mmio_cs3, mmio_rd3});
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({mmio_cs3, mmio_rd3, mmio_wr3, rsp_valid3, busy3, req_ready3} !== 6'b0) begin
      fails++;
      $display("FAIL rmr_async: got cs/rd/wr/rv/busy/rdy=%b expected 000000",
               {mmio_cs3, mmio_rd3, mmio_wr3, rsp_valid3, busy3, req_ready3});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid3 || mmio_cs3 || busy3) bad = 1'b1;
    end
    tests++;
    if (bad || req_ready3 !== 1'b1) begin
      fails++;
      $display("FAIL rmr_after: got activity=%b req_ready=%b expected activity=0 req_ready=1", bad, req_ready3);
    end
  endtask

  // Random traffic checked against a program-order register-file model.
  task automatic test_random(input int n);
    logic [31:0] ref_mem [16];
    logic [53:0] op_q [$];
    logic [31:0] rd_q [$];
    int          seen = 0;
    bit          drv_to = 1'b0;
    bit          done = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    use_fixed = 1'b0;
    fork
      begin
        for (int i = 0; i < n && !drv_to; i++) begin
          logic        w;
          logic [20:0] a;
          logic [31:0] d;
          int          wt;
          w  = 1'($urandom_range(0, 1));
          a  = 21'($urandom);
          d  = $urandom;
          wt = 0;
          @(negedge clk);
          if ($urandom_range(0, 3) == 0) @(negedge clk);
          req_valid = 1'b1; req_wr = w; req_addr = a; req_wdata = d;
          while (!req_ready && wt < 100) begin
            @(negedge clk);
            wt++;
          end
          if (wt >= 100) begin
            drv_to = 1'b1;
            tests++;
            fails++;
            $display("FAIL rand_accept_timeout: got req_ready=0 for 100 cycles expected acceptance");
          end else begin
            if (w) ref_mem[a[3:0]] = d;
            op_q.push_back({w, a, w ? d : ref_mem[a[3:0]]});
          end
          @(posedge clk); #1;
          req_valid = 1'b0;
        end
      end
      begin
        bit          prev_rd = 1'b0;
        logic [53:0] e;
        logic [31:0] x;
        for (int cyc = 0; cyc < 40000 && !done && !drv_to; cyc++) begin
          @(negedge clk);
          rsp_ready = ($urandom_range(0, 2) != 0);
          tests++;
          if (mmio_wr && mmio_rd) begin
            fails++;
            $display("FAIL rand_wr_rd: got wr=1 rd=1 expected never both");
          end
          if (mmio_wr || (mmio_rd && !prev_rd)) begin
            tests++;
            if (op_q.size() == 0) begin
              fails++;
              $display("FAIL rand_extra_op: got strobe addr=%h expected none", mmio_addr);
            end else begin
              e = op_q.pop_front();
              if (e[53] !== mmio_wr || e[52:32] !== mmio_addr || (mmio_wr && e[31:0] !== mmio_wr_data)) begin
                fails++;
                $display("FAIL rand_op%0d: got wr=%b addr=%h data=%h expected wr=%b addr=%h data=%h",
                         seen, mmio_wr, mmio_addr, mmio_wr_data, e[53], e[52:32], e[31:0]);
              end
              if (!mmio_wr) rd_q.push_back(e[31:0]);
              seen++;
            end
          end
          prev_rd = mmio_rd;
          if (rsp_valid && rsp_ready) begin
            tests++;
            if (rd_q.size() == 0) begin
              fails++;
              $display("FAIL rand_extra_rsp: got rdata=%h expected no response", rsp_rdata);
            end else begin
              x = rd_q.pop_front();
              if (rsp_rdata !== x) begin
                fails++;
                $display("FAIL rand_rdata: got %h expected %h", rsp_rdata, x);
              end
            end
          end
          done = (seen >= n) && (rd_q.size() == 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        tests++;
        if (!done) begin
          fails++;
          $display("FAIL rand_complete: got %0d ops with %0d responses pending expected %0d ops 0 pending",
                   seen, rd_q.size(), n);
        end
      end
    join
  endtask

  initial begin
    req_valid = 1'b0; req_wr = 1'b0; req_addr = 21'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    req_valid3 = 1'b0; req_wr3 = 1'b0; req_addr3 = 21'h0; req_wdata3 = 32'h0; rsp_ready3 = 1'b0;
    use_fixed = 1'b0; fixed_rd = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_stall(5);
    test_stall(12);
    test_reset_mid_read();
    test_reset();
    test_random(1000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
